dr_link_tx_arb: RTL and testbench

- Clocked-domain transmitter and round-robin arbiter for one outgoing dual-rail link into the async fabric.
- N_REQ synchronous producers share the link. The block grants one word at a time, encodes it two-phase (TP) or four-phase (FP) dual-rail, and waits for the receiver's completion acknowledge before the next grant.
- It is the clocked counterpart of the dual-rail-to-clock sync stage: its rails feed a completion-detected receiver, whose ack returns here.

---
 rtl/dr_link_pkg.sv | 25 ++
 rtl/dr_link_tx_arb_rr.sv | 30 +++
 rtl/dr_link_tx_arb.sv | 113 +++++++++++
 tb/tb_dr_link_tx_arb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dr_link_pkg.sv
// Shared types and the per-bit dual-rail encoder for the clocked-to-async link transmitter.
package dr_link_pkg;

  typedef enum logic {
    ENC_TP,
    ENC_FP
  } enc_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_RTZ
  } tx_state_t;

  // Next rail pair for one data bit: TP flips exactly one rail, FP drives {d,~d} out of spacer.
  function automatic logic [1:0] dr_encode(input enc_t enc, input logic [1:0] phase_rails,
                                           input logic data);
    logic [1:0] rails;
    if (enc == ENC_FP) rails = {data, ~data};
    else               rails = phase_rails ^ (data ? 2'b10 : 2'b01);
    return rails;
  endfunction

endpackage

// File: rtl/dr_link_tx_arb_rr.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module rr_arb #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dr_link_tx_arb.sv
// Round-robin arbiter and dual-rail (two-phase or four-phase) transmitter for one outgoing
// async link; one token in flight, released by the receiver's completion ack.
module dr_link_tx_arb
  import dr_link_pkg::*;
#(
  parameter               ENC         = "TP",
  parameter  int unsigned WIDTH       = 1,
  parameter  int unsigned N_REQ       = 4,
  parameter  int unsigned SYNC_STAGES = 2,
  parameter  int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned IW          = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0][WIDTH-1:0]  req_data,
  output logic [N_REQ-1:0]             req_ready,
  input  logic                         ack_i,
  output logic [WIDTH-1:0][1:0]        out,
  output logic [IW-1:0]                grant_id,
  output logic                         busy,
  output logic                         err
);

  localparam enc_t        ENC_SEL = (ENC == "FP") ? ENC_FP : ENC_TP;
  localparam int unsigned CW      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] ERR_AT  = CW'(TIMEOUT_CYC - 1);

  tx_state_t              state, state_nxt;
  logic [IW-1:0]          ptr;
  logic [N_REQ-1:0]       gnt;
  logic [IW-1:0]          win;
  logic                   any;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s, ack_prev, ack_evt;
  logic [CW-1:0]          wait_cnt;
  logic                   in_wait;
  logic [WIDTH-1:0]       win_data;
  logic [WIDTH-1:0][1:0]  enc_rails;

  rr_arb #(.N(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );

  assign ack_s     = ack_sync[SYNC_STAGES-1];
  assign ack_evt   = ack_s ^ ack_prev;
  assign in_wait   = (state == WAIT_ACK) || (state == WAIT_RTZ);
  assign busy      = (state != IDLE);
  assign req_ready = (state == IDLE) ? gnt : '0;

  always_comb begin
    enc_rails = '0;
    win_data  = req_data[win];
    for (int unsigned b = 0; b < WIDTH; b++)
      enc_rails[b] = dr_encode(ENC_SEL, out[b], win_data[b]);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (any) state_nxt = SEND;
      SEND:     state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (ENC_SEL == ENC_TP) begin
          if (ack_evt) state_nxt = IDLE;
        end else if (ack_s) begin
          state_nxt = WAIT_RTZ;
        end
      end
      WAIT_RTZ: if (!ack_s) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      out      <= '0;
      ack_sync <= '0;
      ack_prev <= 1'b0;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_i};
      ack_prev <= ack_s;

      // Rails are loaded on the accept edge so they are already valid during SEND.
      if (state == IDLE && any) begin
        out      <= enc_rails;
        grant_id <= win;
        ptr      <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
      end
      if (state == WAIT_ACK && state_nxt == WAIT_RTZ) out <= '0;

      // Counter restarts on every state change, so each wait phase is timed separately;
      // err rises on the edge where a continuing wait brings the count to TIMEOUT_CYC.
      if (state_nxt != state)                   wait_cnt <= '0;
      else if (in_wait && wait_cnt != CNT_MAX)  wait_cnt <= wait_cnt + 1'b1;

      if (TIMEOUT_CYC != 0 && in_wait && state_nxt == state && wait_cnt == ERR_AT)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dr_link_tx_arb.sv
// Randomized self-checking bench for dr_link_tx_arb: a TP/WIDTH=4 and an FP/WIDTH=2 instance
// checked against a transaction-level model (RR pick, word-level rail arithmetic, fixed latencies).
module tb_dr_link_tx_arb;

  localparam int unsigned N    = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned TO   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_tp, ack_tp, busy_tp, err_tp;
  logic [N-1:0]        val_tp, rdy_tp;
  logic [N-1:0][3:0]   dat_tp;
  logic [3:0][1:0]     out_tp;
  logic [1:0]          gid_tp;

  logic                rst_fp, ack_fp, busy_fp, err_fp;
  logic [N-1:0]        val_fp, rdy_fp;
  logic [N-1:0][1:0]   dat_fp;
  logic [1:0][1:0]     out_fp;
  logic [1:0]          gid_fp;

  dr_link_tx_arb #(.ENC("TP"), .WIDTH(4), .N_REQ(N), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TO)) u_tp (
    .clk(clk), .rst(rst_tp), .req_valid(val_tp), .req_data(dat_tp), .req_ready(rdy_tp),
    .ack_i(ack_tp), .out(out_tp), .grant_id(gid_tp), .busy(busy_tp), .err(err_tp));

  dr_link_tx_arb #(.ENC("FP"), .WIDTH(2), .N_REQ(N), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TO)) u_fp (
    .clk(clk), .rst(rst_fp), .req_valid(val_fp), .req_data(dat_fp), .req_ready(rdy_fp),
    .ack_i(ack_fp), .out(out_fp), .grant_id(gid_fp), .busy(busy_fp), .err(err_fp));

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  // Reference model state
  int         ptr_tp, ptr_fp;
  logic [3:0] t_tp, f_tp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [N-1:0] v);
    for (int i = 0; i < int'(N); i++) begin
      int c = (p + i) % int'(N);
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] interleave(input logic [3:0] t, input logic [3:0] f);
    logic [7:0] r;
    for (int b = 0; b < 4; b++) begin
      r[2*b+1] = t[b];
      r[2*b]   = f[b];
    end
    return r;
  endfunction

  function automatic logic [3:0] fp_word(input logic [1:0] d);
    logic [3:0] r;
    for (int b = 0; b < 2; b++) begin
      r[2*b+1] = d[b];
      r[2*b]   = ~d[b];
    end
    return r;
  endfunction

  // Starts and ends on a falling edge.
  task automatic tp_token(input logic [N-1:0] v, input logic [N-1:0][3:0] d,
                          input int unsigned dly, input bit keep, output int w);
    val_tp = v;
    dat_tp = d;
    #1;
    w = rr_pick(ptr_tp, v);
    if (w < 0) begin
      check("tp_ready_none", 32'(rdy_tp), 32'd0);
      @(negedge clk);
      check("tp_idle_none", 32'(busy_tp), 32'd0);
      return;
    end
    check("tp_ready_onehot", 32'(rdy_tp), 32'd1 << w);
    t_tp   = t_tp ^ d[w];
    f_tp   = f_tp ^ ~d[w];
    ptr_tp = (w + 1) % int'(N);
    @(negedge clk);
    check("tp_grant_id", 32'(gid_tp), 32'(w));
    check("tp_rails", 32'(out_tp), 32'(interleave(t_tp, f_tp)));
    check("tp_busy_send", 32'(busy_tp), 32'd1);
    if (!keep) val_tp = '0;
    repeat (dly) begin
      @(negedge clk);
      check("tp_ready_wait", 32'(rdy_tp), 32'd0);
      check("tp_busy_wait", 32'(busy_tp), 32'd1);
    end
    ack_tp = ~ack_tp;
    repeat (SYNC) begin
      @(negedge clk);
      check("tp_busy_sync", 32'(busy_tp), 32'd1);
      check("tp_ready_sync", 32'(rdy_tp), 32'd0);
      check("tp_rails_hold", 32'(out_tp), 32'(interleave(t_tp, f_tp)));
    end
    @(negedge clk);
    check("tp_idle_return", 32'(busy_tp), 32'd0);
  endtask

  task automatic fp_token(input logic [N-1:0] v, input logic [N-1:0][1:0] d,
                          input int unsigned dly, input int unsigned rtz, output int w);
    logic [3:0] exp;
    val_fp = v;
    dat_fp = d;
    #1;
    w = rr_pick(ptr_fp, v);
    check("fp_ready_onehot", 32'(rdy_fp), (w < 0) ? 32'd0 : (32'd1 << w));
    if (w < 0) return;
    ptr_fp = (w + 1) % int'(N);
    exp    = fp_word(d[w]);
    @(negedge clk);
    check("fp_grant_id", 32'(gid_fp), 32'(w));
    check("fp_rails", 32'(out_fp), 32'(exp));
    repeat (dly) begin
      @(negedge clk);
      check("fp_rails_wait", 32'(out_fp), 32'(exp));
      check("fp_ready_wait", 32'(rdy_fp), 32'd0);
    end
    ack_fp = 1'b1;
    repeat (SYNC) begin
      @(negedge clk);
      check("fp_rails_sync", 32'(out_fp), 32'(exp));
      check("fp_busy_sync", 32'(busy_fp), 32'd1);
      check("fp_ready_sync", 32'(rdy_fp), 32'd0);
    end
    @(negedge clk);
    check("fp_spacer", 32'(out_fp), 32'd0);
    check("fp_busy_rtz", 32'(busy_fp), 32'd1);
    repeat (rtz) begin
      @(negedge clk);
      check("fp_spacer_hold", 32'(out_fp), 32'd0);
      check("fp_ready_rtz", 32'(rdy_fp), 32'd0);
    end
    ack_fp = 1'b0;
    repeat (SYNC) begin
      @(negedge clk);
      check("fp_busy_rtz_sync", 32'(busy_fp), 32'd1);
      check("fp_ready_rtz_sync", 32'(rdy_fp), 32'd0);
    end
    @(negedge clk);
    check("fp_idle_return", 32'(busy_fp), 32'd0);
  endtask

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

  initial begin
    int               w;
    int               fair_seq [6] = '{0, 1, 2, 3, 0, 1};
    logic [N-1:0][3:0] d4;
    logic [N-1:0][1:0] d2;
    logic [N-1:0]      v;
    logic [3:0]        to_data;

    rst_tp = 1'b1; rst_fp = 1'b1;
    ack_tp = 1'b0; ack_fp = 1'b0;
    val_tp = '0;   val_fp = '0;
    dat_tp = '0;   dat_fp = '0;
    ptr_tp = 0;    ptr_fp = 0;
    t_tp   = '0;   f_tp   = '0;
    repeat (3) @(negedge clk);
    check("rst_tp_out", 32'(out_tp), 32'd0);
    check("rst_tp_ready", 32'(rdy_tp), 32'd0);
    check("rst_tp_gid", 32'(gid_tp), 32'd0);
    check("rst_tp_busy", 32'(busy_tp), 32'd0);
    check("rst_tp_err", 32'(err_tp), 32'd0);
    check("rst_fp_out", 32'(out_fp), 32'd0);
    check("rst_fp_busy", 32'(busy_fp), 32'd0);
    check("rst_fp_err", 32'(err_fp), 32'd0);
    rst_tp = 1'b0; rst_fp = 1'b0;
    @(negedge clk);

    // Fairness: all valid, immediate ack
    for (int i = 0; i < 6; i++) begin
      d4 = 16'($urandom);
      tp_token(4'b1111, d4, 0, 1'b1, w);
      check("fair_order", 32'(w), 32'(fair_seq[i]));
    end
    // Skip and wrap from pointer 2, then confirm pointer moved to 1
    d4 = 16'($urandom);
    tp_token(4'b0011, d4, 1, 1'b0, w);
    check("wrap_grant", 32'(w), 32'd0);
    d4 = 16'($urandom);
    tp_token(4'b1111, d4, 2, 1'b0, w);
    check("wrap_ptr_next", 32'(w), 32'd1);

    // Directed 4'hA from requester 0, ack 5 cycles after rails change
    d4 = '0;
    d4[0] = 4'hA;
    tp_token(4'b0001, d4, 5, 1'b0, w);

    // Ack edge while idle is ignored and raises no error
    ack_tp = ~ack_tp;
    repeat (4) begin
      @(negedge clk);
      check("spurious_busy", 32'(busy_tp), 32'd0);
      check("spurious_err", 32'(err_tp), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      v  = 4'($urandom_range(0, 15));
      d4 = 16'($urandom);
      tp_token(v, d4, $urandom_range(0, 5), 1'($urandom), w);
    end
    check("tp_no_err", 32'(err_tp), 32'd0);

    // Ack timeout: err on the edge closing the TO-th wait cycle, FSM keeps waiting
    val_tp  = 4'b0001;
    to_data = 4'($urandom);
    dat_tp  = '0;
    dat_tp[0] = to_data;
    #1;
    w = rr_pick(ptr_tp, val_tp);
    check("to_ready", 32'(rdy_tp), 32'd1 << w);
    t_tp   = t_tp ^ to_data;
    f_tp   = f_tp ^ ~to_data;
    ptr_tp = (w + 1) % int'(N);
    @(negedge clk);
    check("to_rails", 32'(out_tp), 32'(interleave(t_tp, f_tp)));
    val_tp = '0;
    for (int k = 1; k <= int'(TO); k++) begin
      @(negedge clk);
      check("to_err_low", 32'(err_tp), 32'd0);
      check("to_busy", 32'(busy_tp), 32'd1);
    end
    @(negedge clk);
    check("to_err_set", 32'(err_tp), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("to_still_waiting", 32'(busy_tp), 32'd1);
    end
    ack_tp = ~ack_tp;
    repeat (SYNC) begin
      @(negedge clk);
      check("to_late_busy", 32'(busy_tp), 32'd1);
    end
    @(negedge clk);
    check("to_late_idle", 32'(busy_tp), 32'd0);
    check("to_err_sticky", 32'(err_tp), 32'd1);

    rst_tp = 1'b1;
    @(negedge clk);
    rst_tp = 1'b0;
    check("tp_rst_err_clr", 32'(err_tp), 32'd0);
    check("tp_rst_out", 32'(out_tp), 32'd0);
    check("tp_rst_gid", 32'(gid_tp), 32'd0);

    // FP directed: data 2'b10 from requester 0
    d2 = '0;
    d2[0] = 2'b10;
    fp_token(4'b0001, d2, 2, 1, w);
    for (int i = 0; i < 12; i++) begin
      v = 4'($urandom_range(1, 15));
      d2 = 8'($urandom);
      fp_token(v, d2, $urandom_range(0, 5), $urandom_range(0, 4), w);
    end
    val_fp = '0;
    check("fp_no_err", 32'(err_fp), 32'd0);

    // Reset during FP WAIT_ACK with the pointer away from 0
    d2 = 8'($urandom);
    val_fp = 4'b0010;
    dat_fp = d2;
    @(negedge clk);
    check("fprst_send_rails", 32'(out_fp), 32'(fp_word(d2[1])));
    @(negedge clk);
    check("fprst_in_wait", 32'(busy_fp), 32'd1);
    val_fp = '0;
    rst_fp = 1'b1;
    @(negedge clk);
    check("fprst_out", 32'(out_fp), 32'd0);
    check("fprst_busy", 32'(busy_fp), 32'd0);
    check("fprst_err", 32'(err_fp), 32'd0);
    rst_fp = 1'b0;
    ptr_fp = 0;
    d2 = 8'($urandom);
    fp_token(4'b1111, d2, 1, 1, w);
    check("fprst_ptr_zero", 32'(w), 32'd0);
    val_fp = '0;

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
